// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the shared multi-cycle FPU: starts ops, stalls EX for L-1 cycles,
// flags completion one cycle later and aborts the op on flush. Stall cycles are counted for the CSR.
module fpu_issue_ctrl #(
  parameter int FPU_NUM_OPS = 5,
  parameter int SEL_W       = $clog2(FPU_NUM_OPS),
  parameter logic [SEL_W-1:0] FPU_ADD  = SEL_W'(0),
  parameter logic [SEL_W-1:0] FPU_MADD = SEL_W'(1),
  parameter logic [SEL_W-1:0] FPU_CVT  = SEL_W'(2),
  parameter int LAT_ADD  = 3,
  parameter int LAT_MADD = 4,
  parameter int LAT_CVT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [SEL_W-1:0] issue_sel,
  input  logic             flush,
  input  logic             hold,
  output logic             fpu_start,
  output logic             fpu_en,
  output logic             fpu_done,
  output logic             ex_stall,
  output logic             busy,
  output logic [31:0]      stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] lat;
  logic       acc;

  always_comb begin
    lat = 3'd1;
    if (issue_sel == FPU_ADD)       lat = 3'(LAT_ADD);
    else if (issue_sel == FPU_MADD) lat = 3'(LAT_MADD);
    else if (issue_sel == FPU_CVT)  lat = 3'(LAT_CVT);
  end

  assign acc = (state == IDLE) && issue_valid && !flush && !hold;

  assign fpu_start = acc;
  assign fpu_en    = acc || (state == BUSY);
  assign fpu_done  = (acc && (lat == 3'd1)) || (state == DONE);
  assign ex_stall  = (acc && (lat != 3'd1)) || (state == BUSY);
  assign busy      = (state != IDLE);

  // cnt holds L-2; BUSY exits on cnt<=1 so the result lands in cycle T+L-1.
  // A 2-cycle op skips BUSY entirely: its only stall cycle is the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (ex_stall) stall_cnt <= stall_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (acc && (lat != 3'd1)) begin
            cnt   <= lat - 3'd2;
            state <= (lat == 3'd2) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (flush)            state <= IDLE;
          else if (cnt <= 3'd1) state <= DONE;
          else                  cnt   <= cnt - 3'd1;
        end
        DONE: begin
          if (flush || !hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: IDLE decode table plus hand-written multi-cycle sequences.
module tb_fpu_issue_ctrl;
  localparam logic [2:0] ADD = 3'd0, MADD = 3'd1, CVT = 3'd2, SGNJ = 3'd3, ASEL = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_sel = 3'd0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        fpu_start, fpu_en, fpu_done, ex_stall, busy;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_issue_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_sel(issue_sel),
    .flush(flush), .hold(hold), .fpu_start(fpu_start), .fpu_en(fpu_en),
    .fpu_done(fpu_done), .ex_stall(ex_stall), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] s;
    logic       f;
    logic       h;
    logic [4:0] e;   // {start, en, done, stall, busy}
  } vec_t;

  vec_t tbl [8];

  // Drive one cycle's inputs just after the edge, then sample at the falling edge.
  task automatic drive(input logic v, input logic [2:0] s, input logic f,
                       input logic h, input logic r);
    @(posedge clk);
    #1;
    rst = r; issue_valid = v; issue_sel = s; flush = f; hold = h;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {fpu_start, fpu_en, fpu_done, ex_stall, busy};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {start,en,done,stall,busy} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] exp);
    n_checks++;
    if (stall_cnt !== exp) begin
      n_fail++;
      $display("FAIL %s: stall_cnt got %h expected %h", name, stall_cnt, exp);
    end
  endtask

  task automatic do_reset(input string name);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk({name, "_rst_outs"}, 5'b00000);
    chk_cnt({name, "_rst_cnt"}, 32'd0);
  endtask

  task automatic add_seq(input string name);
    drive(1'b1, ADD, 1'b0, 1'b0, 1'b0); chk({name, "_T"},   5'b11010);
    drive(1'b0, ADD, 1'b0, 1'b0, 1'b0); chk({name, "_T1"},  5'b01011);
    drive(1'b0, ADD, 1'b0, 1'b0, 1'b0); chk({name, "_T2"},  5'b00101);
    drive(1'b0, ADD, 1'b0, 1'b0, 1'b0); chk({name, "_T3"},  5'b00000);
  endtask

  initial begin
    tbl[0] = '{1'b0, ADD,    1'b0, 1'b0, 5'b00000};
    tbl[1] = '{1'b1, ADD,    1'b1, 1'b0, 5'b00000};
    tbl[2] = '{1'b1, ADD,    1'b0, 1'b1, 5'b00000};
    tbl[3] = '{1'b1, SGNJ,   1'b0, 1'b0, 5'b11100};
    tbl[4] = '{1'b1, ASEL,   1'b0, 1'b0, 5'b11100};
    tbl[5] = '{1'b1, 3'd5,   1'b0, 1'b0, 5'b11100};
    tbl[6] = '{1'b1, SGNJ,   1'b0, 1'b1, 5'b00000};
    tbl[7] = '{1'b1, MADD,   1'b1, 1'b0, 5'b00000};

    // Reset state and first ADD
    do_reset("init");
    add_seq("add");
    chk_cnt("add_cnt", 32'd2);

    // IDLE decode table: none of these leave IDLE
    do_reset("tbl");
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].h, 1'b0);
      chk($sformatf("tbl%0d", i), tbl[i].e);
    end
    drive(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    chk("tbl_idle", 5'b00000);
    chk_cnt("tbl_cnt", 32'd0);

    // SGNJ then MADD back to back
    do_reset("sm");
    drive(1'b1, SGNJ, 1'b0, 1'b0, 1'b0); chk("sm_sgnj",  5'b11100);
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("sm_madd",  5'b11010);
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("sm_busy1", 5'b01011);
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("sm_busy2", 5'b01011);
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("sm_done",  5'b00101);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b0); chk("sm_idle",  5'b00000);
    chk_cnt("sm_cnt", 32'd3);

    // MADD flushed in its first BUSY cycle
    do_reset("fl");
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("fl_T",  5'b11010);
    drive(1'b1, MADD, 1'b1, 1'b0, 1'b0); chk("fl_T1", 5'b01011);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b0); chk("fl_T2", 5'b00000);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b0); chk("fl_T3", 5'b00000);
    chk_cnt("fl_cnt", 32'd2);

    // CVT completion held in DONE, then a second CVT with no bubble
    do_reset("cv");
    drive(1'b1, CVT, 1'b0, 1'b0, 1'b0); chk("cv_T",   5'b11010);
    drive(1'b1, CVT, 1'b0, 1'b1, 1'b0); chk("cv_T1",  5'b00101);
    drive(1'b1, CVT, 1'b0, 1'b1, 1'b0); chk("cv_T2",  5'b00101);
    drive(1'b1, CVT, 1'b0, 1'b0, 1'b0); chk("cv_T3",  5'b00101);
    drive(1'b1, CVT, 1'b0, 1'b0, 1'b0); chk("cv_T4",  5'b11010);
    drive(1'b0, CVT, 1'b0, 1'b0, 1'b0); chk("cv_T5",  5'b00101);
    drive(1'b0, CVT, 1'b0, 1'b0, 1'b0); chk("cv_T6",  5'b00000);
    chk_cnt("cv_cnt", 32'd2);

    // DONE with flush and hold together still exits
    do_reset("df");
    drive(1'b1, CVT, 1'b0, 1'b0, 1'b0); chk("df_T",  5'b11010);
    drive(1'b1, CVT, 1'b1, 1'b1, 1'b0); chk("df_T1", 5'b00101);
    drive(1'b0, CVT, 1'b0, 1'b1, 1'b0); chk("df_T2", 5'b00000);

    // Reset in the middle of a MADD
    do_reset("mr");
    drive(1'b1, MADD, 1'b0, 1'b0, 1'b0); chk("mr_T",  5'b11010);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b1); chk("mr_T1", 5'b01011);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b0); chk("mr_T2", 5'b00000);
    chk_cnt("mr_cnt0", 32'd0);
    drive(1'b0, MADD, 1'b0, 1'b0, 1'b0); chk("mr_T3", 5'b00000);
    add_seq("mr_add");
    chk_cnt("mr_cnt", 32'd2);

    // Counter wrap
    do_reset("wr");
    force dut.stall_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.stall_cnt;
    chk_cnt("wr_preset", 32'hFFFF_FFFF);
    add_seq("wr_add");
    chk_cnt("wr_cnt", 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
